// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock,
// with a start/busy/done handshake and a registered result.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BIN_W-1:0] bin_sh_q, bin_sh_d;
  logic [BCD_W-1:0] work_q, work_d;
  logic             ovf_w_q, ovf_w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             overflow_q, overflow_d;

  logic [BCD_W-1:0] adj_c;
  logic [BCD_W-1:0] shift_c;
  logic             carry_c;

  // Add-3 adjust of every working digit >= 5, 4-bit arithmetic per digit
  always_comb begin
    adj_c = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift the adjusted digits left, pulling in the binary MSB; the top bit leaving is the overflow carry
  always_comb begin
    shift_c = {adj_c[BCD_W-2:0], bin_sh_q[BIN_W-1]};
    carry_c = adj_c[BCD_W-1];
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    bin_sh_d   = bin_sh_q;
    work_d     = work_q;
    ovf_w_d    = ovf_w_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_SHIFT;
          busy_d   = 1'b1;
          bin_sh_d = bin;
          work_d   = '0;
          ovf_w_d  = 1'b0;
          cnt_d    = CNT_W'(BIN_W);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        busy_d   = 1'b1;
        work_d   = shift_c;
        bin_sh_d = bin_sh_q << 1;
        ovf_w_d  = ovf_w_q | carry_c;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          bcd_d      = shift_c;
          overflow_d = ovf_w_q | carry_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bin_sh_q   <= '0;
      work_q     <= '0;
      ovf_w_q    <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bin_sh_q   <= bin_sh_d;
      work_q     <= work_d;
      ovf_w_q    <= ovf_w_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance, table vectors,
// hand-written handshake/reset sequences, random and exhaustive checks
// against an arithmetic reference model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [7:0]  bin1, bin2;
  logic        busy1, busy2, done1, done2, ovf1, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  typedef struct {
    bit          use2;
    logic [7:0]  v;
    logic [11:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value mod 10^digits written as decimal digits, overflow when value >= 10^digits
  function automatic logic [11:0] ref_bcd(input int v, input int digits);
    logic [11:0] r;
    int m, lim;
    r = '0;
    lim = (digits == 2) ? 100 : 1000;
    m = v % lim;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v, input int digits);
    return v >= ((digits == 2) ? 100 : 1000);
  endfunction

  // bcd must hold steady on every cycle without done, except across a reset
  logic        rst_e = 1'b1;
  logic [11:0] prev_bcd = '0;
  always @(posedge clk) rst_e <= rst;
  always @(negedge clk) begin
    if (!rst_e && !done1) chk("bcd_stable", 32'(bcd1), 32'(prev_bcd));
    prev_bcd = bcd1;
  end

  // One conversion: drive start for one edge, then wait (bounded) for done
  task automatic run_conv(input bit use2, input logic [7:0] v,
                          output logic [11:0] b, output logic o,
                          output int lat, output int busy_cnt);
    @(posedge clk); #1;
    if (use2) begin start2 = 1'b1; bin2 = v; end
    else      begin start1 = 1'b1; bin1 = v; end
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    lat = 0; busy_cnt = 0; b = '0; o = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (use2 ? done2 : done1) begin
        lat = i;
        b = use2 ? {4'h0, bcd2} : bcd1;
        o = use2 ? ovf2 : ovf1;
        break;
      end
      if (use2 ? busy2 : busy1) busy_cnt++;
    end
    if (lat == 0) chk("done_timeout", 32'(0), 32'(1));
  endtask

  vec_t        vecs[$];
  logic [11:0] b;
  logic        o;
  int          lat, bc, ndone, v;

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; bin1 = '0; bin2 = '0;
    vecs.push_back('{1'b0, 8'd255, 12'h255, 1'b0});
    vecs.push_back('{1'b0, 8'd0,   12'h000, 1'b0});
    vecs.push_back('{1'b0, 8'd9,   12'h009, 1'b0});
    vecs.push_back('{1'b0, 8'd100, 12'h100, 1'b0});
    vecs.push_back('{1'b0, 8'd199, 12'h199, 1'b0});
    vecs.push_back('{1'b1, 8'd99,  12'h099, 1'b0});
    vecs.push_back('{1'b1, 8'd100, 12'h000, 1'b1});
    vecs.push_back('{1'b1, 8'd255, 12'h055, 1'b1});
    vecs.push_back('{1'b1, 8'd5,   12'h005, 1'b0});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'(0));
    chk("rst_done", 32'(done1), 32'(0));
    chk("rst_bcd",  32'(bcd1),  32'(0));
    chk("rst_ovf",  32'(ovf1),  32'(0));
    chk("rst_bcd2", 32'(bcd2),  32'(0));

    // Table vectors, including latency and busy length
    foreach (vecs[i]) begin
      run_conv(vecs[i].use2, vecs[i].v, b, o, lat, bc);
      chk("vec_bcd",  32'(b),   32'(vecs[i].exp_bcd));
      chk("vec_ovf",  32'(o),   32'(vecs[i].exp_ovf));
      chk("vec_lat",  32'(lat), 32'(9));
      chk("vec_busy", 32'(bc),  32'(8));
    end

    // Back-to-back: start held during the done cycle, no idle gap
    run_conv(1'b0, 8'd0, b, o, lat, bc);
    chk("b2b_first", 32'(b), 32'h000);
    start1 = 1'b1; bin1 = 8'd9;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("b2b_busy_nogap", 32'(busy1), 32'(1));
    lat = 0;
    for (int i = 2; i <= 30; i++) begin
      @(negedge clk);
      if (done1) begin lat = i; break; end
    end
    chk("b2b_lat",    32'(lat),  32'(9));
    chk("b2b_second", 32'(bcd1), 32'h009);

    // Start while busy is ignored
    @(posedge clk); #1 start1 = 1'b1; bin1 = 8'd123;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); @(posedge clk); #1 start1 = 1'b1; bin1 = 8'd45;
    @(posedge clk); #1 start1 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        chk("ign_bcd", 32'(bcd1), 32'h123);
      end
    end
    chk("ign_ndone", 32'(ndone), 32'(1));

    // Reset mid-conversion abandons it
    @(posedge clk); #1 start1 = 1'b1; bin1 = 8'd77;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_busy", 32'(busy1), 32'(0));
    chk("mid_rst_bcd",  32'(bcd1),  32'(0));
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'(0));
    run_conv(1'b0, 8'd208, b, o, lat, bc);
    chk("post_rst_bcd", 32'(b), 32'h208);

    // Random values on both widths against the reference model
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 255));
      run_conv(i[0], 8'(v), b, o, lat, bc);
      chk("rnd_bcd", 32'(b), 32'(ref_bcd(v, i[0] ? 2 : 3)));
      chk("rnd_ovf", 32'(o), 32'(ref_ovf(v, i[0] ? 2 : 3)));
    end

    // Exhaustive sweep on the 3-digit instance
    for (int x = 0; x < 256; x++) begin
      run_conv(1'b0, 8'(x), b, o, lat, bc);
      chk("sweep_bcd", 32'(b), 32'(ref_bcd(x, 3)));
      chk("sweep_ovf", 32'(o), 32'(0));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
